// File: rtl/encoder_sampler.sv
// Encoder front end: synchronises and deglitches the encoder pulse, counts qualified
// rising edges into a saturating 14-bit count, and issues the periodic PID_timer strobe.
module encoder_sampler #(
  parameter int unsigned SAMPLE_PERIOD = 5_000_000,
  parameter int unsigned FILTER_LEN    = 8
) (
  input  logic        i_Clk,
  input  logic        reset,
  input  logic        i_Enc_A,
  input  logic        reset_nop,
  output logic [13:0] number_of_pulses,
  output logic        PID_timer
);

  localparam logic [7:0]  FILT_LEN = 8'(FILTER_LEN);
  localparam logic [25:0] RELOAD   = 26'(SAMPLE_PERIOD - 1);
  localparam logic [13:0] CNT_MAX  = 14'h3FFF;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } filt_state_e;

  logic        sync1_q, sync2_q;
  logic        enc_s;
  filt_state_e state_q;
  logic [7:0]  stab_q;
  logic [7:0]  stab_inc;
  logic        edge_q;
  logic [13:0] cnt_q, cnt_d;
  logic [25:0] timer_q;
  logic        strobe_q;

  // Two-flop synchroniser; the raw input is used nowhere else.
  always_ff @(posedge i_Clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_Enc_A;
      sync2_q <= sync1_q;
    end
  end

  assign enc_s    = sync2_q;
  assign stab_inc = stab_q + 8'd1;

  // Level filter: a change is accepted after FILTER_LEN identical samples; only rises emit edge_q.
  always_ff @(posedge i_Clk) begin
    if (reset) begin
      state_q <= LOW;
      stab_q  <= '0;
      edge_q  <= 1'b0;
    end else begin
      edge_q <= 1'b0;
      case (state_q)
        LOW: begin
          if (enc_s) begin
            state_q <= RISE_CHK;
            stab_q  <= 8'd1;
          end
        end
        RISE_CHK: begin
          if (!enc_s) begin
            state_q <= LOW;
            stab_q  <= '0;
          end else if (stab_inc == FILT_LEN) begin
            state_q <= HIGH;
            stab_q  <= '0;
            edge_q  <= 1'b1;
          end else begin
            stab_q <= stab_inc;
          end
        end
        HIGH: begin
          if (!enc_s) begin
            state_q <= FALL_CHK;
            stab_q  <= 8'd1;
          end
        end
        FALL_CHK: begin
          if (enc_s) begin
            state_q <= HIGH;
            stab_q  <= '0;
          end else if (stab_inc == FILT_LEN) begin
            state_q <= LOW;
            stab_q  <= '0;
          end else begin
            stab_q <= stab_inc;
          end
        end
        default: begin
          state_q <= LOW;
          stab_q  <= '0;
        end
      endcase
    end
  end

  // Clear request outranks a coincident edge, which is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (reset_nop) begin
      cnt_d = '0;
    end else if (edge_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 14'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Free-running sample timer; ignores reset_nop so the sample period never drifts.
  always_ff @(posedge i_Clk) begin
    if (reset) begin
      timer_q  <= RELOAD;
      strobe_q <= 1'b0;
    end else if (timer_q == '0) begin
      timer_q  <= RELOAD;
      strobe_q <= 1'b1;
    end else begin
      timer_q  <= timer_q - 26'd1;
      strobe_q <= 1'b0;
    end
  end

  assign number_of_pulses = cnt_q;
  assign PID_timer        = strobe_q;

endmodule

// File: tb/tb_encoder_sampler.sv
// Bench for encoder_sampler: two instances (default-like filter with handshake, and a
// short filter driven into saturation) checked cycle by cycle against a run-length model.
module tb_encoder_sampler;

  localparam int F0  = 8;
  localparam int SP0 = 1000;
  localparam int F1  = 2;
  localparam int SP1 = 4096;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, a0 = 1'b0, nop0 = 1'b0;
  logic        rst1 = 1'b1, a1 = 1'b0, nop1 = 1'b0;
  logic [13:0] cnt0, cnt1;
  logic        pid0, pid1;

  encoder_sampler #(.SAMPLE_PERIOD(SP0), .FILTER_LEN(F0)) dut0 (
    .i_Clk(clk), .reset(rst0), .i_Enc_A(a0), .reset_nop(nop0),
    .number_of_pulses(cnt0), .PID_timer(pid0)
  );

  encoder_sampler #(.SAMPLE_PERIOD(SP1), .FILTER_LEN(F1)) dut1 (
    .i_Clk(clk), .reset(rst1), .i_Enc_A(a1), .reset_nop(nop1),
    .number_of_pulses(cnt1), .PID_timer(pid1)
  );

  typedef struct packed {
    logic [13:0] cnt;
    logic        pid;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state per instance: input history seen by the synchroniser,
  // accepted level, length of the current run disagreeing with it, pending rise.
  int m_h1[2], m_h2[2], m_lvl[2], m_run[2], m_pend[2], m_cnt[2], m_since[2], m_pid[2];
  int m_f[2]  = '{F0, F1};
  int m_sp[2] = '{SP0, SP1};
  int hs_en   = 0;
  int hs_left = 0;

  task automatic model_step(input int d, input logic a, input logic nop, input logic rst);
    exp_t e;
    int   v;
    if (rst) begin
      m_h1[d] = 0; m_h2[d] = 0; m_lvl[d] = 0; m_run[d] = 0;
      m_pend[d] = 0; m_cnt[d] = 0; m_since[d] = 0; m_pid[d] = 0;
    end else begin
      v = m_h2[d];
      if (nop) m_cnt[d] = 0;
      else if (m_pend[d] != 0 && m_cnt[d] < 16383) m_cnt[d] = m_cnt[d] + 1;
      m_pend[d] = 0;
      if (v != m_lvl[d]) m_run[d] = m_run[d] + 1;
      else m_run[d] = 0;
      if (m_run[d] == m_f[d]) begin
        m_lvl[d]  = v;
        m_run[d]  = 0;
        m_pend[d] = v;
      end
      m_h2[d]    = m_h1[d];
      m_h1[d]    = a ? 1 : 0;
      m_since[d] = m_since[d] + 1;
      m_pid[d]   = ((m_since[d] % m_sp[d]) == 0) ? 1 : 0;
    end
    e.cnt = 14'(m_cnt[d]);
    e.pid = (m_pid[d] != 0);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic tick0(input logic a, input logic nop, input logic rst);
    logic eff;
    eff  = nop | (hs_left > 0);
    a0   = a;
    nop0 = eff;
    rst0 = rst;
    @(posedge clk);
    model_step(0, a, eff, rst);
    if (hs_left > 0) hs_left = hs_left - 1;
    if (hs_en != 0 && m_pid[0] != 0) hs_left = 8;
    @(negedge clk);
  endtask

  task automatic tick1(input logic a, input logic nop, input logic rst);
    a1   = a;
    nop1 = nop;
    rst1 = rst;
    @(posedge clk);
    model_step(1, a, nop, rst);
    @(negedge clk);
  endtask

  task automatic pulse0(input int hi, input int lo);
    repeat (hi) tick0(1'b1, 1'b0, 1'b0);
    repeat (lo) tick0(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each registered output against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("count0", int'(cnt0), int'(e.cnt));
      check("pid0", int'(pid0), int'(e.pid));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("count1", int'(cnt1), int'(e.cnt));
      check("pid1", int'(pid1), int'(e.pid));
    end
  end

  task automatic flow0();
    @(negedge clk);
    repeat (3) tick0(1'b0, 1'b0, 1'b1);
    // clean pulses
    repeat (5) pulse0(20, 20);
    // glitches, a minimum-width pulse, and a short dip inside a long high
    repeat (3) pulse0(7, 20);
    pulse0(8, 20);
    pulse0(15, 3);
    pulse0(15, 20);
    // edge coincident with clear, then edge right after clear falls
    for (int i = 0; i < 40; i++) tick0(i < 20, i == 10, 1'b0);
    for (int i = 0; i < 40; i++) tick0(i < 20, i == 9, 1'b0);
    // random pulse widths with the PID handshake active
    hs_en = 1;
    repeat (100) begin
      pulse0($urandom_range(2, 30), $urandom_range(2, 30));
      if ($urandom_range(0, 9) == 0) tick0(1'b0, 1'b1, 1'b0);
    end
    while (m_since[0] < 3200) tick0(1'b0, 1'b0, 1'b0);
    // reset while the filter is part-way through a rise
    repeat (20) tick0(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick0(1'b1, 1'b0, 1'b0);
    tick0(1'b1, 1'b0, 1'b1);
    repeat (30) tick0(1'b1, 1'b0, 1'b0);
    repeat (20) tick0(1'b0, 1'b0, 1'b0);
    repeat (28) pulse0(20, 20);
  endtask

  task automatic flow1();
    @(negedge clk);
    repeat (3) tick1(1'b0, 1'b0, 1'b1);
    repeat (16390) begin
      tick1(1'b1, 1'b0, 1'b0);
      tick1(1'b1, 1'b0, 1'b0);
      tick1(1'b0, 1'b0, 1'b0);
      tick1(1'b0, 1'b0, 1'b0);
    end
    repeat (10) tick1(1'b0, 1'b0, 1'b0);
    tick1(1'b0, 1'b1, 1'b0);
    repeat (4) tick1(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    fork
      flow0();
      flow1();
    join
    repeat (3) @(negedge clk);
    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
